decode_stage: RTL and testbench
===============================

// Module: decode_stage
// PURPOSE
//  Instruction decode pipeline stage for the 16-bit WISC core; the producer side of the ALU control interface.
//  Accepts {instr, pc} from fetch over valid/ready, splits the instruction into opcode/funct/imm/register fields and registers them.
//  Its outputs feed register-file read ports and the ALU (opcode, funct, imm8) directly.
//  Includes a 1-entry skid buffer so that in_ready does not depend combinationally on out_ready.
//  Sticky HALT state; squash on flush.
// PARAMETERS
//  W     16  instruction/PC width; only 16 is supported
//  SKID  1   1: skid buffer present (registered in_ready); 0: in_ready = ~halted & (out_ready | ~out_valid)
// PORTS
//  clk          in   1   clock, all state updates on rising edge
//  rst_n        in   1   synchronous active-low reset
//  flush        in   1   squash all held instructions (branch/jump redirect)
//  in_valid     in   1   fetch presents an instruction
//  in_ready     out  1   stage accepts this cycle
//  in_instr     in   16  raw instruction
//  in_pc        in   16  PC+2 of in_instr
//  out_valid    out  1   decoded bundle valid
//  out_ready    in   1   downstream accepts bundle
//  out_opcode   out  5   instr[15:11]
//  out_funct    out  2   instr[1:0]
//  out_imm8     out  8   I2 format: instr[7:0]; I1 format: {3'b0,instr[4:0]}; otherwise 0
//  out_disp11   out  11  instr[10:0] (J/JAL), else 0
//  out_rs       out  3   instr[10:8]
//  out_rt       out  3   instr[7:5]
//  out_rd       out  3   destination register index (see BEHAVIOUR)
//  out_reg_wr   out  1   instruction writes out_rd
//  out_pc       out  16  in_pc carried along
//  out_halt     out  1   opcode 00000
//  out_illegal  out  1   opcode 00010 or 00011 (unsupported)
//  halted       out  1   FSM is in HALT
// BEHAVIOUR
//  Reset (rst_n=0 at edge): out_valid=0, skid empty, FSM=RUN, halted=0; all data outputs=0; in_ready=0 during reset.
//  Decode is combinational on the input; the bundle appears on out_* one cycle after acceptance (latency 1).
//  Rd/reg_wr rules:
//    R (11011, 11010, 111xx, 11001): rd=instr[4:2], wr=1
//    I1 ALU (010xx, 101xx), LD 10001: rd=instr[7:5], wr=1
//    STU 10011: rd=instr[10:8], wr=1;  ST 10000: wr=0
//    LBI 11000, SLBI 10010: rd=instr[10:8], wr=1
//    JAL 00110, JALR 00111: rd=3'd7, wr=1
//    Branches 011xx, J 00100, JR 00101, HALT, NOP 00001, illegal: rd=0, wr=0
//  I2 formats (imm8 = instr[7:0]): 011xx, 11000, 10010, 00101, 00111.
//    I1 formats (imm8 = 5-bit zero-padded): 010xx, 101xx, 1000x, 10011.
//  Handshake: transfer on valid&ready at each side. in_ready = (FSM==RUN) & ~skid_valid.
//    Accepted with out_valid & ~out_ready: bundle goes to skid.
//    Output drained: skid moves to output, else the new input does.
//    Simultaneous drain and accept with skid empty: the new bundle replaces the output in the same edge.
//  Output holds stable while out_valid & ~out_ready (no field changes).
//  FSM RUN->HALT when a HALT instruction is accepted.
//    In HALT: in_ready=0; held bundles (incl. the HALT) still drain.
//    HALT->RUN only on flush or reset.
//  flush: output and skid cleared at the edge. An in_valid in that cycle is dropped (in_ready forced 0 while flush=1).
//    flush has priority over every other event; reset has priority over flush.
//  Illegal opcodes pass through with out_illegal=1, wr=0; no state change.
// TESTING
//  ADD r3=r1+r2: instr 0xD94C, out_ready=1 -> next cycle opcode=11011 rs=1 rt=2 rd=3 funct=00 reg_wr=1.
//  ADDI 0x415F then LBI 0xC480 back-to-back -> imm8=0x1F rd=2 wr=1; then imm8=0x80 rd=4 wr=1.
//  JAL 0x3005 -> disp11=0x005 rd=7 reg_wr=1; ST 0x8000 -> reg_wr=0.
//  Backpressure: out_ready=0 for 3 cycles while 2 instrs sent -> second held in skid, in_ready=0.
//    Release -> in-order delivery, no loss or duplication.
//  HALT 0x0000 accepted -> halted=1 next cycle, in_ready=0, out_halt=1.
//    flush -> halted=0, out_valid=0.
//  Reset asserted mid-backpressure with skid full -> out_valid=0 and in_ready=1 on the first cycle after rst_n=1.

Source files
------------

// File: rtl/decode_stage.sv
// decode_stage: WISC 16-bit decode stage with 1-entry skid buffer, sticky HALT and flush squash.
module decode_stage #(
  parameter int W    = 16,
  parameter bit SKID = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_instr,
  input  logic [W-1:0] in_pc,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [4:0]   out_opcode,
  output logic [1:0]   out_funct,
  output logic [7:0]   out_imm8,
  output logic [10:0]  out_disp11,
  output logic [2:0]   out_rs,
  output logic [2:0]   out_rt,
  output logic [2:0]   out_rd,
  output logic         out_reg_wr,
  output logic [W-1:0] out_pc,
  output logic         out_halt,
  output logic         out_illegal,
  output logic         halted
);
  typedef struct packed {
    logic [4:0]   opcode;
    logic [1:0]   funct;
    logic [7:0]   imm8;
    logic [10:0]  disp11;
    logic [2:0]   rs;
    logic [2:0]   rt;
    logic [2:0]   rd;
    logic         reg_wr;
    logic [W-1:0] pc;
    logic         halt;
    logic         illegal;
  } bundle_t;
  bundle_t dec, out_q, out_d, skid_q, skid_d;
  logic out_valid_q, out_valid_d, skid_valid_q, skid_valid_d, halted_q, halted_d;
  logic [4:0] op;
  logic i1, i2, r_fmt, rt_dst, rs_dst, link, move, accept;
  assign op = in_instr[15:11];
  always_comb begin
    i2     = op[4:2] == 3'b011 || op == 5'b11000 || op == 5'b10010 || op == 5'b00101 || op == 5'b00111;
    i1     = op[4:2] == 3'b010 || op[4:2] == 3'b101 || op[4:1] == 4'b1000 || op == 5'b10011;
    r_fmt  = op[4:3] == 2'b11 && op != 5'b11000;
    rt_dst = op[4:2] == 3'b010 || op[4:2] == 3'b101 || op == 5'b10001;
    rs_dst = op == 5'b10011 || op == 5'b11000 || op == 5'b10010;
    link   = op[4:1] == 4'b0011;
    dec.opcode  = op;
    dec.funct   = in_instr[1:0];
    dec.imm8    = i2 ? in_instr[7:0] : i1 ? {3'b000, in_instr[4:0]} : 8'h00;
    dec.disp11  = (op == 5'b00100 || op == 5'b00110) ? in_instr[10:0] : 11'h000;
    dec.rs      = in_instr[10:8];
    dec.rt      = in_instr[7:5];
    dec.rd      = r_fmt ? in_instr[4:2] : rt_dst ? in_instr[7:5] : rs_dst ? in_instr[10:8] : link ? 3'd7 : 3'd0;
    dec.reg_wr  = r_fmt | rt_dst | rs_dst | link;
    dec.pc      = in_pc;
    dec.halt    = op == 5'b00000;
    dec.illegal = op[4:1] == 4'b0001;
  end
  // Without the skid, acceptance is only allowed when the output register is free to move.
  assign in_ready = rst_n & ~flush & ~halted_q & (SKID ? ~skid_valid_q : (out_ready | ~out_valid_q));
  always_comb begin
    move         = ~out_valid_q | out_ready;
    accept       = in_valid & in_ready;
    out_valid_d  = flush ? 1'b0 : move ? (skid_valid_q | accept) : out_valid_q;
    out_d        = flush ? '0 : move ? (skid_valid_q ? skid_q : accept ? dec : out_q) : out_q;
    skid_valid_d = flush ? 1'b0 : move ? 1'b0 : (skid_valid_q | accept);
    skid_d       = flush ? '0 : (~move & accept) ? dec : skid_q;
    halted_d     = flush ? 1'b0 : halted_q | (accept & dec.halt);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_q        <= '0;
      skid_valid_q <= 1'b0;
      skid_q       <= '0;
      halted_q     <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_q        <= out_d;
      skid_valid_q <= skid_valid_d;
      skid_q       <= skid_d;
      halted_q     <= halted_d;
    end
  end
  assign out_valid   = out_valid_q;
  assign out_opcode  = out_q.opcode;
  assign out_funct   = out_q.funct;
  assign out_imm8    = out_q.imm8;
  assign out_disp11  = out_q.disp11;
  assign out_rs      = out_q.rs;
  assign out_rt      = out_q.rt;
  assign out_rd      = out_q.rd;
  assign out_reg_wr  = out_q.reg_wr;
  assign out_pc      = out_q.pc;
  assign out_halt    = out_q.halt;
  assign out_illegal = out_q.illegal;
  assign halted      = halted_q;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed + random checks of decode_stage against a queue-based reference model.
module tb_decode_stage;
  logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [15:0] in_instr = '0, in_pc = '0;
  logic in_ready, out_valid, out_reg_wr, out_halt, out_illegal, halted;
  logic [4:0] out_opcode;
  logic [1:0] out_funct;
  logic [7:0] out_imm8;
  logic [10:0] out_disp11;
  logic [2:0] out_rs, out_rt, out_rd;
  logic [15:0] out_pc;
  logic [53:0] obs;
  decode_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_opcode(out_opcode), .out_funct(out_funct), .out_imm8(out_imm8), .out_disp11(out_disp11),
    .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd), .out_reg_wr(out_reg_wr), .out_pc(out_pc),
    .out_halt(out_halt), .out_illegal(out_illegal), .halted(halted)
  );
  always #5 clk = ~clk;
  assign obs = {out_opcode, out_funct, out_imm8, out_disp11, out_rs, out_rt, out_rd, out_reg_wr,
                out_pc, out_halt, out_illegal};
  int vectors = 0, miscompares = 0;
  logic [53:0] q[$];
  logic m_halted = 1'b0, m_zero = 1'b1;
  function automatic logic [53:0] ref_dec(input logic [15:0] i, input logic [15:0] pc);
    logic [4:0] op;
    logic [7:0] imm;
    logic [10:0] d;
    logic [2:0] rd;
    logic wr;
    op = i[15:11]; imm = 8'h00; d = 11'h000; rd = 3'd0; wr = 1'b0;
    casez (op)
      5'b011??, 5'b11000, 5'b10010, 5'b00101, 5'b00111: imm = i[7:0];
      5'b010??, 5'b101??, 5'b1000?, 5'b10011:           imm = {3'b000, i[4:0]};
      default: ;
    endcase
    casez (op)
      5'b11011, 5'b11010, 5'b111??, 5'b11001: begin rd = i[4:2];  wr = 1'b1; end
      5'b010??, 5'b101??, 5'b10001:           begin rd = i[7:5];  wr = 1'b1; end
      5'b10011, 5'b11000, 5'b10010:           begin rd = i[10:8]; wr = 1'b1; end
      5'b00110, 5'b00111:                     begin rd = 3'd7;    wr = 1'b1; end
      default: ;
    endcase
    if (op == 5'b00100 || op == 5'b00110) d = i[10:0];
    return {op, i[1:0], imm, d, i[10:8], i[7:5], rd, wr, pc, op == 5'd0, op == 5'd2 || op == 5'd3};
  endfunction
  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    vectors++;
    assert (o === e) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask
  // One clock: drive at negedge, check in_ready, advance model, check registered state after the edge.
  task automatic cyc(input logic r, input logic f, input logic v, input logic [15:0] ins,
                     input logic [15:0] pc, input logic ordy);
    logic exp_rdy;
    @(negedge clk);
    rst_n = r; flush = f; in_valid = v; in_instr = ins; in_pc = pc; out_ready = ordy;
    #1;
    exp_rdy = r & ~f & ~m_halted & (q.size() < 2);
    chk("in_ready", in_ready, exp_rdy);
    if (!r || f) begin
      q.delete(); m_halted = 1'b0; m_zero = 1'b1;
    end else begin
      if (q.size() > 0 && ordy) void'(q.pop_front());
      if (v && exp_rdy) begin
        q.push_back(ref_dec(ins, pc));
        m_zero = 1'b0;
        if (ins[15:11] == 5'd0) m_halted = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    chk("out_valid", out_valid, q.size() > 0);
    chk("halted", halted, m_halted);
    if (q.size() > 0) chk("bundle", obs, q[0]);
    else if (m_zero) chk("bundle_zero", obs, 54'd0);
  endtask
  initial begin
    cyc(0, 0, 0, 16'h0000, 16'h0000, 0);
    cyc(0, 0, 0, 16'h0000, 16'h0000, 1);
    chk("rst_pc", out_pc, 16'h0000);
    cyc(1, 0, 1, 16'hD94C, 16'h0002, 1);
    chk("add_op", out_opcode, 5'b11011);
    chk("add_rs_rt_rd", {out_rs, out_rt, out_rd}, {3'd1, 3'd2, 3'd3});
    chk("add_funct_wr", {out_funct, out_reg_wr}, 3'b001);
    cyc(1, 0, 1, 16'h415F, 16'h0004, 1);
    chk("addi", {out_imm8, out_rd, out_reg_wr}, {8'h1F, 3'd2, 1'b1});
    cyc(1, 0, 1, 16'hC480, 16'h0006, 1);
    chk("lbi", {out_imm8, out_rd, out_reg_wr}, {8'h80, 3'd4, 1'b1});
    cyc(1, 0, 1, 16'h3005, 16'h0008, 1);
    chk("jal", {out_disp11, out_rd, out_reg_wr}, {11'h005, 3'd7, 1'b1});
    cyc(1, 0, 1, 16'h8000, 16'h000A, 1);
    chk("st", out_reg_wr, 1'b0);
    cyc(1, 0, 1, 16'h1000, 16'h000C, 1);
    chk("illegal", {out_illegal, out_reg_wr}, 2'b10);
    cyc(1, 0, 0, 16'h0000, 16'h0000, 1);
    // Backpressure: two instructions in while the consumer stalls.
    cyc(1, 0, 1, 16'hD94C, 16'h0010, 0);
    cyc(1, 0, 1, 16'h415F, 16'h0012, 0);
    cyc(1, 0, 1, 16'hC480, 16'h0014, 0);
    chk("bp_in_ready", in_ready, 1'b0);
    cyc(1, 0, 0, 16'h0000, 16'h0000, 1);
    cyc(1, 0, 0, 16'h0000, 16'h0000, 1);
    cyc(1, 0, 0, 16'h0000, 16'h0000, 1);
    // HALT, then flush recovers.
    cyc(1, 0, 1, 16'h0000, 16'h0020, 1);
    chk("halt", {halted, out_halt}, 2'b11);
    cyc(1, 0, 1, 16'hD94C, 16'h0022, 0);
    cyc(1, 1, 1, 16'hD94C, 16'h0024, 0);
    chk("flush", {halted, out_valid}, 2'b00);
    // Reset with the skid full.
    cyc(1, 0, 1, 16'hD94C, 16'h0030, 0);
    cyc(1, 0, 1, 16'h415F, 16'h0032, 0);
    cyc(0, 0, 1, 16'hC480, 16'h0034, 0);
    cyc(1, 0, 1, 16'hC480, 16'h0036, 1);
    for (int n = 0; n < 2000; n++)
      cyc(($urandom % 200) != 0, ($urandom % 16) == 0, ($urandom % 4) != 0,
          16'($urandom), 16'($urandom), ($urandom % 3) != 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
